// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Registered ALU with start/done handshake, status flags and an
//               iterative shift-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alus,
  input  logic [WIDTH-1:0] ac,
  input  logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int             CW     = $clog2(WIDTH) + 1;
  localparam int             MSB    = WIDTH - 1;
  localparam logic [CW-1:0]  c_LAST = CW'(WIDTH - 1);

  localparam logic [3:0] c_OP_CLR  = 4'h0;
  localparam logic [3:0] c_OP_ADD  = 4'h1;
  localparam logic [3:0] c_OP_SUB  = 4'h2;
  localparam logic [3:0] c_OP_INC  = 4'h3;
  localparam logic [3:0] c_OP_MOVR = 4'h4;
  localparam logic [3:0] c_OP_AND  = 4'h5;
  localparam logic [3:0] c_OP_OR   = 4'h6;
  localparam logic [3:0] c_OP_NOT  = 4'h7;
  localparam logic [3:0] c_OP_XOR  = 4'h8;
  localparam logic [3:0] c_OP_LDAC = 4'h9;
  localparam logic [3:0] c_OP_SHL  = 4'hA;
  localparam logic [3:0] c_OP_SHR  = 4'hB;
  localparam logic [3:0] c_OP_MUL  = 4'hC;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_dout, w_dout_nxt;
  logic                 r_z, r_n, r_c, r_v;
  logic                 w_z_nxt, w_n_nxt, w_c_nxt, w_v_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_err, w_err_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [2*WIDTH-1:0]   r_mcand, w_mcand_nxt;
  logic [WIDTH-1:0]     r_mplier, w_mplier_nxt;
  logic [2*WIDTH-1:0]   r_acc, w_acc_nxt;

  logic [WIDTH:0]       w_sum;
  logic [WIDTH-1:0]     w_res;
  logic                 w_c, w_v, w_legal;
  logic [2*WIDTH-1:0]   w_acc_step;
  logic [WIDTH-1:0]     w_prod_lo;
  logic [WIDTH-1:0]     w_prod_hi;

  // Single-cycle operations evaluate straight from the ports: the operands
  // are only needed on the start edge itself.
  always_comb begin
    w_sum   = '0;
    w_res   = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_legal = 1'b1;
    case (alus)
      c_OP_CLR:  w_res = '0;
      c_OP_ADD: begin
        w_sum = {1'b0, ac} + {1'b0, bus};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (ac[MSB] == bus[MSB]) && (w_res[MSB] != ac[MSB]);
      end
      c_OP_SUB: begin
        w_sum = {1'b0, ac} - {1'b0, bus};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (ac[MSB] != bus[MSB]) && (w_res[MSB] != ac[MSB]);
      end
      c_OP_INC: begin
        w_sum = {1'b0, ac} + {{WIDTH{1'b0}}, 1'b1};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = ~ac[MSB] & w_res[MSB];
      end
      c_OP_MOVR: w_res = bus;
      c_OP_AND:  w_res = ac & bus;
      c_OP_OR:   w_res = ac | bus;
      c_OP_NOT:  w_res = ~ac;
      c_OP_XOR:  w_res = ac ^ bus;
      c_OP_LDAC: w_res = bus;
      c_OP_SHL: begin
        w_res = {ac[WIDTH-2:0], 1'b0};
        w_c   = ac[MSB];
      end
      c_OP_SHR: begin
        w_res = {1'b0, ac[WIDTH-1:1]};
        w_c   = ac[0];
      end
      c_OP_MUL:  w_res = '0;
      default:   w_legal = 1'b0;
    endcase
  end

  // One multiplier bit per cycle; the final step feeds the result directly.
  assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_prod_lo  = w_acc_step[WIDTH-1:0];
  assign w_prod_hi  = w_acc_step[2*WIDTH-1:WIDTH];

  always_comb begin
    w_state_nxt  = r_state;
    w_dout_nxt   = r_dout;
    w_z_nxt      = r_z;
    w_n_nxt      = r_n;
    w_c_nxt      = r_c;
    w_v_nxt      = r_v;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_cnt_nxt    = r_cnt;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_acc_nxt    = r_acc;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (alus == c_OP_MUL) begin
            w_mcand_nxt  = {{WIDTH{1'b0}}, ac};
            w_mplier_nxt = bus;
            w_acc_nxt    = '0;
            w_cnt_nxt    = '0;
            w_busy_nxt   = 1'b1;
            w_state_nxt  = S_MUL;
          end else if (!w_legal) begin
            w_done_nxt = 1'b1;
            w_err_nxt  = 1'b1;
          end else begin
            w_dout_nxt = w_res;
            w_z_nxt    = (w_res == '0);
            w_n_nxt    = w_res[MSB];
            w_c_nxt    = w_c;
            w_v_nxt    = w_v;
            w_done_nxt = 1'b1;
          end
        end
      end
      S_MUL: begin
        w_acc_nxt    = w_acc_step;
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = r_mplier >> 1;
        w_cnt_nxt    = r_cnt + CW'(1);
        if (r_cnt == c_LAST) begin
          w_dout_nxt  = w_prod_lo;
          w_z_nxt     = (w_prod_lo == '0);
          w_n_nxt     = w_prod_lo[MSB];
          w_c_nxt     = |w_prod_hi;
          w_v_nxt     = 1'b0;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_dout   <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_dout   <= w_dout_nxt;
      r_z      <= w_z_nxt;
      r_n      <= w_n_nxt;
      r_c      <= w_c_nxt;
      r_v      <= w_v_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_acc    <= w_acc_nxt;
    end
  end

  assign dout   = r_dout;
  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;
  assign flag_z = r_z;
  assign flag_n = r_n;
  assign flag_c = r_c;
  assign flag_v = r_v;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed self-checking bench for alu_seq (WIDTH=8) with an
//               arithmetic reference model checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   alus = 4'h0;
  logic [W-1:0] ac = '0;
  logic [W-1:0] bus = '0;
  logic [W-1:0] dout;
  logic         busy, done, err, flag_z, flag_n, flag_c, flag_v;

  int n_tests = 0;
  int n_fail  = 0;
  logic cmp_en = 1'b0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alus(alus), .ac(ac), .bus(bus),
    .dout(dout), .busy(busy), .done(done), .err(err),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         legal;
    logic [W-1:0] res;
    logic         z, n, c, v;
  } mres_t;

  function automatic int sx(input logic [W-1:0] x);
    return x[W-1] ? int'(x) - 256 : int'(x);
  endfunction

  function automatic mres_t model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    mres_t r;
    int s, sv;
    r = '0;
    r.legal = 1'b1;
    case (op)
      4'h0: r.res = 8'h00;
      4'h1: begin s = int'(a) + int'(b); sv = sx(a) + sx(b);
                  r.res = 8'(s % 256); r.c = (s > 255); r.v = (sv > 127 || sv < -128); end
      4'h2: begin s = int'(a) - int'(b); sv = sx(a) - sx(b);
                  r.res = 8'((s + 256) % 256); r.c = (a < b); r.v = (sv > 127 || sv < -128); end
      4'h3: begin s = int'(a) + 1; sv = sx(a) + 1;
                  r.res = 8'(s % 256); r.c = (s > 255); r.v = (sv > 127); end
      4'h4, 4'h9: r.res = b;
      4'h5: r.res = a & b;
      4'h6: r.res = a | b;
      4'h7: r.res = ~a;
      4'h8: r.res = a ^ b;
      4'hA: begin r.res = 8'((int'(a) * 2) % 256); r.c = (a >= 8'd128); end
      4'hB: begin r.res = 8'(int'(a) / 2); r.c = a[0]; end
      4'hC: begin s = int'(a) * int'(b); r.res = 8'(s % 256); r.c = (s > 255); end
      default: r.legal = 1'b0;
    endcase
    r.z = (r.res == 8'h00);
    r.n = (r.res >= 8'd128);
    return r;
  endfunction

  // Reference model: a pending MUL result is delivered W edges after start.
  mres_t        w_m;
  mres_t        m_pend;
  int           m_left;
  logic [W-1:0] m_dout;
  logic         m_z, m_n, m_c, m_v, m_busy, m_done, m_err;

  assign w_m = model_op(alus, ac, bus);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0; m_dout <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
      m_z <= 1'b0; m_n <= 1'b0; m_c <= 1'b0; m_v <= 1'b0; m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      m_err  <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_dout <= m_pend.res; m_z <= m_pend.z; m_n <= m_pend.n;
          m_c <= m_pend.c; m_v <= 1'b0; m_done <= 1'b1; m_busy <= 1'b0;
        end
      end else if (start) begin
        if (!w_m.legal) begin
          m_done <= 1'b1; m_err <= 1'b1;
        end else if (alus == 4'hC) begin
          m_left <= W; m_busy <= 1'b1; m_pend <= w_m;
        end else begin
          m_dout <= w_m.res; m_z <= w_m.z; m_n <= w_m.n;
          m_c <= w_m.c; m_v <= w_m.v; m_done <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model dout", 16'(dout), 16'(m_dout));
      chk("model busy", 16'(busy), 16'(m_busy));
      chk("model done", 16'(done), 16'(m_done));
      chk("model err",  16'(err),  16'(m_err));
      chk("model flags", 16'({flag_z, flag_n, flag_c, flag_v}), 16'({m_z, m_n, m_c, m_v}));
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; alus = op; ac = a; bus = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_res(input string name, input logic [W-1:0] exp_d, input logic [3:0] exp_f);
    chk({name, " done"}, 16'(done), 16'd1);
    chk({name, " dout"}, 16'(dout), 16'(exp_d));
    chk({name, " znc v"}, 16'({flag_z, flag_n, flag_c, flag_v}), 16'(exp_f));
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 20; i++) begin
      if (done) break;
      @(negedge clk);
    end
    chk({name, " done within bound"}, 16'(done), 16'd1);
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b, res;
    logic [3:0]   f;
  } vec_t;
  vec_t tbl[10];

  initial begin
    tbl[0] = '{4'h0, 8'h12, 8'h34, 8'h00, 4'b1000};
    tbl[1] = '{4'h5, 8'hF0, 8'h3C, 8'h30, 4'b0000};
    tbl[2] = '{4'h6, 8'hF0, 8'h0C, 8'hFC, 4'b0100};
    tbl[3] = '{4'h8, 8'hFF, 8'h0F, 8'hF0, 4'b0100};
    tbl[4] = '{4'h7, 8'h0F, 8'h00, 8'hF0, 4'b0100};
    tbl[5] = '{4'h9, 8'h00, 8'h9A, 8'h9A, 4'b0100};
    tbl[6] = '{4'hB, 8'h81, 8'h00, 8'h40, 4'b0010};
    tbl[7] = '{4'hA, 8'h40, 8'h00, 8'h80, 4'b0100};
    tbl[8] = '{4'h3, 8'hFF, 8'h00, 8'h00, 4'b1010};
    tbl[9] = '{4'h4, 8'h77, 8'h00, 8'h00, 4'b1000};

    repeat (3) @(negedge clk);
    chk("reset dout", 16'(dout), 16'h0);
    chk("reset ctl", 16'({busy, done, err}), 16'h0);
    chk("reset flags", 16'({flag_z, flag_n, flag_c, flag_v}), 16'h0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    issue(4'h1, 8'hFF, 8'h01);
    chk_res("ADD FF+01", 8'h00, 4'b1010);
    @(negedge clk);
    chk("ADD done single cycle", 16'(done), 16'd0);

    issue(4'h2, 8'h80, 8'h01);
    chk_res("SUB 80-01", 8'h7F, 4'b0001);
    issue(4'h2, 8'h01, 8'h02);
    chk_res("SUB 01-02", 8'hFF, 4'b0110);

    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      chk_res($sformatf("vec%0d", i), tbl[i].res, tbl[i].f);
    end

    issue(4'hC, 8'h0F, 8'h11);
    for (int k = 0; k < 7; k++) begin
      chk("MUL busy", 16'({busy, done}), 16'b10);
      @(negedge clk);
    end
    chk("MUL busy last", 16'({busy, done}), 16'b10);
    @(negedge clk);
    chk_res("MUL 0F*11", 8'hFF, 4'b0100);
    chk("MUL busy cleared", 16'(busy), 16'd0);

    issue(4'hC, 8'h10, 8'h10);
    wait_done("MUL 10*10");
    chk_res("MUL 10*10", 8'h00, 4'b1010);

    issue(4'hC, 8'h03, 8'h05);
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      start = 1'b1; alus = 4'h1; ac = 8'(k + 2); bus = 8'h01;
      @(negedge clk);
    end
    start = 1'b0;
    chk("ignored start done", 16'(done), 16'd0);
    @(negedge clk);
    chk_res("MUL 03*05", 8'h0F, 4'b0000);
    start = 1'b1; alus = 4'hA; ac = 8'h81; bus = 8'h00;
    @(negedge clk);
    start = 1'b0;
    chk_res("SHL b2b", 8'h02, 4'b0010);

    issue(4'hC, 8'h0F, 8'h11);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort dout", 16'(dout), 16'h0);
    chk("abort ctl", 16'({busy, done, err}), 16'h0);
    chk("abort flags", 16'({flag_z, flag_n, flag_c, flag_v}), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("no done after abort", 16'(done), 16'd0);
    end

    issue(4'h3, 8'h7F, 8'h00);
    chk_res("INC 7F", 8'h80, 4'b0101);

    issue(4'h1, 8'hAA, 8'hAB);
    chk_res("ADD AA+AB", 8'h55, 4'b0011);
    issue(4'hE, 8'h12, 8'h34);
    chk("illegal err", 16'({err, done}), 16'b11);
    chk("illegal dout", 16'(dout), 16'h55);
    chk("illegal flags", 16'({flag_z, flag_n, flag_c, flag_v}), 16'b0011);
    @(negedge clk);
    chk("illegal pulse", 16'({err, done}), 16'b00);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
